// File: rtl/lab2_pkg.sv
`default_nettype none
// ============================================================================
// Package : lab2_pkg
// Brief   : Shared types and widths for the truth-table sweep driver.
// Rev     : 1.0  initial release
// ============================================================================
package lab2_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    // Driven vector width ({x,y,z,w}) and truth-table width (2**VEC_W)
    localparam int VEC_W  = 4;
    localparam int TT_W   = 16;
    // Ones count must hold 16 without wrapping
    localparam int ONES_W = 5;

    // Settle counter width for a given settle length
    function automatic int cnt_width(input int settle);
        return $clog2(settle + 1) + 1;
    endfunction

endpackage : lab2_pkg
`default_nettype wire

// File: rtl/tt_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module  : tt_sweep_driver
// Brief   : Drives {x,y,z,w} through all 16 vectors, samples f_in after a
//           settle delay, builds a truth table + ones count and compares the
//           table to a captured golden value.
// Rev     : 1.0  initial release
// ============================================================================
module tt_sweep_driver
    import lab2_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TT_W-1:0]   golden,
    input  logic              f_in,
    output logic              x,
    output logic              y,
    output logic              z,
    output logic              w,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   truth_table,
    output logic [ONES_W-1:0] ones_count,
    output logic              match
);

    localparam int               CNT_W    = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_SETTLE = CNT_W'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0] c_LAST   = {VEC_W{1'b1}};

    sweep_state_t      r_state;
    logic [VEC_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [TT_W-1:0]   r_tt;
    logic [TT_W-1:0]   r_golden;
    logic [ONES_W-1:0] r_ones;
    logic              r_busy;
    logic              r_done;
    logic              r_match;

    // Table and ones count as they will be once the current vector is sampled
    logic [TT_W-1:0]   w_tt_next;
    logic [ONES_W-1:0] w_ones_next;

    assign w_tt_next   = r_tt | (TT_W'(f_in) << r_idx);
    assign w_ones_next = r_ones + ONES_W'(f_in);

    // Sweep FSM with settle counter, vector index and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_tt     <= '0;
            r_golden <= '0;
            r_ones   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_match  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= RUN;
                        r_idx    <= '0;
                        r_cnt    <= c_SETTLE;
                        r_busy   <= 1'b1;
                        r_tt     <= '0;
                        r_ones   <= '0;
                        r_match  <= 1'b0;
                        r_golden <= golden;
                    end
                end
                RUN: begin
                    // abort beats a same-cycle final sample; partial results stay
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_tt   <= w_tt_next;
                        r_ones <= w_ones_next;
                        if (r_idx == c_LAST) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_match <= (w_tt_next == r_golden);
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_cnt <= c_SETTLE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Vector comes straight from the index register (x is the MSB)
    assign {x, y, z, w}  = r_idx;
    assign busy          = r_busy;
    assign done          = r_done;
    assign truth_table   = r_tt;
    assign ones_count    = r_ones;
    assign match         = r_match;

endmodule : tt_sweep_driver
`default_nettype wire

// File: tb/tb_tt_sweep_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_tt_sweep_driver
// Brief   : Self-checking bench for tt_sweep_driver (S=2 and S=0 instances),
//           with a table-lookup model of the function stage.
// Rev     : 1.0  initial release
// ============================================================================
module tb_tt_sweep_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start2, abort;
    logic [15:0] golden;
    logic [15:0] func0, func2;

    logic        x0, y0, z0, w0, busy0, done0, match0;
    logic        x2, y2, z2, w2, busy2, done2, match2;
    logic [15:0] tt0, tt2;
    logic [4:0]  ones0, ones2;
    logic        f0, f2;
    logic        sel;

    logic [3:0]  m_vec;
    logic        m_busy, m_done, m_match;
    logic [15:0] m_tt;
    logic [4:0]  m_ones;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Function stage modelled as a 16-entry lookup on the driven vector
    assign f0 = func0[{x0, y0, z0, w0}];
    assign f2 = func2[{x2, y2, z2, w2}];

    assign m_vec   = sel ? {x2, y2, z2, w2} : {x0, y0, z0, w0};
    assign m_busy  = sel ? busy2  : busy0;
    assign m_done  = sel ? done2  : done0;
    assign m_match = sel ? match2 : match0;
    assign m_tt    = sel ? tt2    : tt0;
    assign m_ones  = sel ? ones2  : ones0;

    tt_sweep_driver #(.SETTLE_CYCLES(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .golden(golden),
        .f_in(f2), .x(x2), .y(y2), .z(z2), .w(w2), .busy(busy2), .done(done2),
        .truth_table(tt2), .ones_count(ones2), .match(match2)
    );

    tt_sweep_driver #(.SETTLE_CYCLES(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .golden(golden),
        .f_in(f0), .x(x0), .y(y0), .z(z0), .w(w0), .busy(busy0), .done(done0),
        .truth_table(tt0), .ones_count(ones0), .match(match0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit s2, input logic v);
        if (s2) start2 = v;
        else    start0 = v;
    endtask

    // One full sweep; returns sampled just after the done edge.
    // hold_start keeps start high afterwards; mid_pulse pulses start during RUN.
    task automatic run_sweep(input bit s2, input logic [15:0] func, input logic [15:0] gold,
                             input bit hold_start, input bit mid_pulse);
        int per, total, got, busy_cnt;
        per   = s2 ? 3 : 1;
        total = 16 * per;
        sel   = s2;
        if (s2) func2 = func;
        else    func0 = func;
        golden = gold;
        set_start(s2, 1'b1);
        tick();                                   // edge E0
        if (!hold_start) set_start(s2, 1'b0);
        golden = ~gold;                           // captured value must be used
        check("busy_after_start", m_busy, 1);
        check("tt_cleared", m_tt, 0);
        check("ones_cleared", m_ones, 0);
        check("vec_start", m_vec, 0);
        busy_cnt = 1;
        got      = -1;
        for (int k = 1; k <= total + 8; k++) begin
            if (mid_pulse && k == 5) set_start(s2, 1'b1);
            if (mid_pulse && k == 6) set_start(s2, 1'b0);
            tick();
            if (m_done) begin
                got = k;
                break;
            end
            if (m_busy) busy_cnt++;
            if (k < total) check("vec_during_run", m_vec, k / per);
        end
        check("done_latency", got, total);
        check("busy_cycles", busy_cnt, total);
        check("busy_low_at_done", m_busy, 0);
        check("truth_table", m_tt, func);
        check("ones_count", m_ones, $countones(func));
        check("match", m_match, func == gold);
        check("vec_at_done", m_vec, 15);
        if (!hold_start) begin
            tick();
            check("done_one_cycle", m_done, 0);
            check("tt_holds", m_tt, func);
            check("vec_holds", m_vec, 15);
        end
    endtask

    initial begin
        logic [15:0] fr, gr;
        bit          seen_done;

        rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; abort = 1'b0;
        golden = '0; func0 = '0; func2 = '0; sel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {busy2, busy0}, 0);
        check("rst_done", {done2, done0}, 0);
        check("rst_vec", {x2, y2, z2, w2, x0, y0, z0, w0}, 0);
        check("rst_tt", {tt2, tt0}, 0);
        check("rst_ones_match", {ones2, ones0, match2, match0}, 0);
        rst_n = 1'b1;
        tick();

        // LS138 function stage, S=2, matching golden, with a start pulse mid-run
        run_sweep(1'b1, 16'h54AA, 16'h54AA, 1'b0, 1'b1);
        // Same stage, golden off by one bit
        run_sweep(1'b1, 16'h54AA, 16'h54AB, 1'b0, 1'b0);
        // f_in tied high, S=0
        run_sweep(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        // f_in tied low, S=0: ones_count zero, table zero
        run_sweep(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Randomized tables on both instances
        for (int i = 0; i < 6; i++) begin
            fr = 16'($urandom);
            gr = ($urandom_range(0, 1) == 0) ? fr : (fr ^ (16'h1 << $urandom_range(0, 15)));
            run_sweep(i[0], fr, gr, 1'b0, 1'b0);
        end

        // Abort 10 cycles into an S=2 sweep
        fr = 16'($urandom);
        sel = 1'b1; func2 = fr; golden = fr;
        start2 = 1'b1;
        tick();                                    // E0
        start2 = 1'b0;
        repeat (9) tick();                         // after E0+9
        check("abort_busy_before", busy2, 1);
        abort = 1'b1;
        tick();                                    // E0+10
        abort = 1'b0;
        check("abort_busy", busy2, 0);
        check("abort_done", done2, 0);
        check("abort_tt", tt2, fr & 16'h0007);
        check("abort_ones", ones2, $countones(fr & 16'h0007));
        check("abort_match", match2, 0);
        check("abort_vec", {x2, y2, z2, w2}, 3);
        seen_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done2 || busy2) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        // abort while idle is ignored; next sweep is clean
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_sweep(1'b1, 16'h54AA, 16'h54AA, 1'b0, 1'b0);

        // Asynchronous reset mid-sweep
        sel = 1'b1; func2 = 16'hFFFF;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy2, 0);
        check("arst_vec", {x2, y2, z2, w2}, 0);
        check("arst_tt", tt2, 0);
        check("arst_ones", ones2, 0);
        check("arst_done_match", {done2, match2}, 0);
        #1 rst_n = 1'b1;
        tick();
        fr = 16'($urandom);
        run_sweep(1'b1, fr, fr, 1'b0, 1'b0);

        // start held high, S=0: back-to-back sweeps with one idle cycle
        fr = 16'($urandom);
        run_sweep(1'b0, fr, fr, 1'b1, 1'b0);
        tick();
        check("b2b_idle_busy", busy0, 0);
        check("b2b_idle_done", done0, 0);
        gr = 16'($urandom);
        run_sweep(1'b0, gr, fr, 1'b1, 1'b0);
        start0 = 1'b0;
        tick();
        tick();
        check("b2b_end_idle", busy0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_tt_sweep_driver
`default_nettype wire
